// File: rtl/skin_bin_pkg.sv
// Shared constants and types for the skin-colour binarizer.
// Optional build macro: SKIN_BIN_MAJORITY_EN (3-tap horizontal majority filter).
package skin_bin_pkg;

  localparam int unsigned PIX_W = 8;

  localparam logic [PIX_W-1:0] CB_MIN_DEF = 8'd77;
  localparam logic [PIX_W-1:0] CB_MAX_DEF = 8'd127;
  localparam logic [PIX_W-1:0] CR_MIN_DEF = 8'd133;
  localparam logic [PIX_W-1:0] CR_MAX_DEF = 8'd173;

  localparam logic [PIX_W-1:0] MASK_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] MASK_OFF = 8'h00;

`ifdef SKIN_BIN_MAJORITY_EN
  localparam int unsigned LATENCY = 3;
`else
  localparam int unsigned LATENCY = 2;
`endif

  // Video timing bundle carried alongside the pixel.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

endpackage

// File: rtl/skin_bin_sync_delay.sv
// N-stage shift register with synchronous reset, used to align video timing with the mask pixel.
module skin_bin_sync_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] shift_q;

  // Shift one stage per clock; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        shift_q[i] <= shift_q[i-1];
      end
    end
  end

  assign dout = shift_q[DEPTH-1];

endmodule

// File: rtl/skin_bin.sv
// Skin-colour binarizer: classifies Cb/Cr against a fixed rectangle and emits a 0xFF/0x00 mask.
// Optional build macro: SKIN_BIN_MAJORITY_EN adds a 3-tap horizontal majority filter (+1 clock).
module skin_bin
  import skin_bin_pkg::*;
#(
  parameter logic [PIX_W-1:0] CB_MIN = CB_MIN_DEF,
  parameter logic [PIX_W-1:0] CB_MAX = CB_MAX_DEF,
  parameter logic [PIX_W-1:0] CR_MIN = CR_MIN_DEF,
  parameter logic [PIX_W-1:0] CR_MAX = CR_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] cb,
  input  logic [PIX_W-1:0] cr,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [PIX_W-1:0] bin_rgb,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out
);

  logic [PIX_W-1:0] cb_s1_q, cr_s1_q;
  logic             de_s1_q;
  logic             skin_c;
  logic             cls_c;
  logic [PIX_W-1:0] bin_d, bin_q;
  sync_t            sync_in, sync_out;

  // Stage 1: capture chroma and data enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cb_s1_q <= '0;
      cr_s1_q <= '0;
      de_s1_q <= 1'b0;
    end else begin
      cb_s1_q <= cb;
      cr_s1_q <= cr;
      de_s1_q <= de_in;
    end
  end

  // Inclusive rectangular chroma test; blanked pixels classify as 0.
  always_comb begin
    skin_c = (cb_s1_q >= CB_MIN) && (cb_s1_q <= CB_MAX) &&
             (cr_s1_q >= CR_MIN) && (cr_s1_q <= CR_MAX);
    cls_c  = skin_c && de_s1_q;
  end

`ifdef SKIN_BIN_MAJORITY_EN
  logic cls_q, cls_prev_q, de_s2_q;

  // Classified-bit history: cls_prev_q = pixel n-1, cls_q = pixel n, cls_c = pixel n+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q      <= 1'b0;
      cls_prev_q <= 1'b0;
      de_s2_q    <= 1'b0;
    end else begin
      cls_q      <= cls_c;
      cls_prev_q <= cls_q;
      de_s2_q    <= de_s1_q;
    end
  end

  // 2-of-3 vote around the centre pixel, forced off when the centre is blanked.
  always_comb begin
    bin_d = MASK_OFF;
    if (de_s2_q && ((cls_prev_q && cls_q) || (cls_q && cls_c) || (cls_prev_q && cls_c))) begin
      bin_d = MASK_ON;
    end
  end
`else
  // Direct mask from the stage-2 classification.
  always_comb begin
    bin_d = MASK_OFF;
    if (cls_c) begin
      bin_d = MASK_ON;
    end
  end
`endif

  // Output mask register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= MASK_OFF;
    end else begin
      bin_q <= bin_d;
    end
  end

  assign sync_in = '{de: de_in, hsync: hsync_in, vsync: vsync_in};

  skin_bin_sync_delay #(
    .DEPTH (LATENCY),
    .WIDTH ($bits(sync_t))
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (sync_in),
    .dout (sync_out)
  );

  assign bin_rgb   = bin_q;
  assign de_out    = sync_out.de;
  assign hsync_out = sync_out.hsync;
  assign vsync_out = sync_out.vsync;

endmodule

// File: tb/tb_skin_bin.sv
// Directed self-checking bench for skin_bin.
module tb_skin_bin;
  import skin_bin_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cb, cr;
  logic       de_in, hsync_in, vsync_in;
  logic [7:0] bin_rgb;
  logic       de_out, hsync_out, vsync_out;

  int n_checks = 0;
  int n_fail   = 0;

  skin_bin dut (
    .clk       (clk),
    .rst       (rst),
    .cb        (cb),
    .cr        (cr),
    .de_in     (de_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .bin_rgb   (bin_rgb),
    .de_out    (de_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eb, input logic ed,
                         input logic eh, input logic ev);
    chk({tag, ".bin"}, bin_rgb, eb);
    chk({tag, ".de"}, 8'(de_out), 8'(ed));
    chk({tag, ".hs"}, 8'(hsync_out), 8'(eh));
    chk({tag, ".vs"}, 8'(vsync_out), 8'(ev));
  endtask

  task automatic drive(input logic [7:0] b, input logic [7:0] r, input logic d,
                       input logic h, input logic v);
    cb = b; cr = r; de_in = d; hsync_in = h; vsync_in = v;
  endtask

  // Send one pixel surrounded by idle pixels, then check the outputs exactly LATENCY clocks later.
  task automatic px(input string tag, input logic [7:0] b, input logic [7:0] r, input logic d,
                    input logic h, input logic v, input logic [7:0] eb);
    @(negedge clk); drive(b, r, d, h, v);
    @(negedge clk); drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (LATENCY - 1) @(posedge clk);
    #1;
    chk_all(tag, eb, d, h, v);
  endtask

`ifdef SKIN_BIN_MAJORITY_EN
  logic [7:0] mcb  [8] = '{8'd20, 8'd120, 8'd20, 8'd20, 8'd120, 8'd120, 8'd120, 8'd20};
  logic [7:0] mexp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
`endif

  initial begin
    rst = 1'b1;
    drive(8'd120, 8'd140, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);

`ifndef SKIN_BIN_MAJORITY_EN
    px("cb_lo_cr_hi", 8'd20,  8'd200, 1'b1, 1'b0, 1'b0, 8'h00);
    px("cr_hi",       8'd120, 8'd200, 1'b1, 1'b0, 1'b0, 8'h00);
    px("cb_lo",       8'd20,  8'd140, 1'b1, 1'b0, 1'b0, 8'h00);
    px("skin",        8'd120, 8'd140, 1'b1, 1'b0, 1'b0, 8'hFF);
    px("skin_blank",  8'd120, 8'd140, 1'b0, 1'b0, 1'b0, 8'h00);
    px("bound_min",   8'd77,  8'd133, 1'b1, 1'b0, 1'b0, 8'hFF);
    px("bound_max",   8'd127, 8'd173, 1'b1, 1'b0, 1'b0, 8'hFF);
    px("cb_76",       8'd76,  8'd140, 1'b1, 1'b0, 1'b0, 8'h00);
    px("cb_128",      8'd128, 8'd140, 1'b1, 1'b0, 1'b0, 8'h00);
    px("cr_132",      8'd100, 8'd132, 1'b1, 1'b0, 1'b0, 8'h00);
    px("cr_174",      8'd100, 8'd174, 1'b1, 1'b0, 1'b0, 8'h00);
    px("cb_77_cr_173", 8'd77, 8'd173, 1'b1, 1'b0, 1'b0, 8'hFF);
    px("hsync_pulse", 8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 8'h00);
    px("vsync_pulse", 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 8'h00);
    px("hs_vs_skin",  8'd100, 8'd150, 1'b1, 1'b1, 1'b1, 8'hFF);
`else
    // One line: isolated skin pixel is voted out, a run of 3 survives end to end.
    for (int i = 0; i < 8 + int'(LATENCY); i++) begin
      @(negedge clk);
      if (i < 8) drive(mcb[i], 8'd140, 1'b1, 1'b0, 1'b0);
      else       drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (i >= int'(LATENCY) - 1 && i - (int'(LATENCY) - 1) < 8)
        chk_all($sformatf("maj_px%0d", i - (int'(LATENCY) - 1)),
                mexp[i - (int'(LATENCY) - 1)], 1'b1, 1'b0, 1'b0);
    end
    repeat (4) @(posedge clk);
`endif

    // Continuous skin stream, then reset mid-stream.
    @(negedge clk); drive(8'd120, 8'd140, 1'b1, 1'b1, 1'b0);
    repeat (LATENCY + 2) @(posedge clk);
    #1;
    chk_all("stream_steady", 8'hFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= int'(LATENCY); k++) begin
      @(posedge clk); #1;
      if (k < int'(LATENCY)) chk_all($sformatf("post_rst_k%0d", k), 8'h00, 1'b0, 1'b0, 1'b0);
      else                   chk_all("post_rst_first", 8'hFF, 1'b1, 1'b1, 1'b0);
    end

    @(negedge clk); drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
